// File: rtl/btn_cond_pkg.sv
// Shared types and default timing for the push-button conditioning slice.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        LO_STABLE = 2'd0,
        LO_CHECK  = 2'd1,
        HI_STABLE = 2'd2,
        HI_CHECK  = 2'd3
    } btn_state_t;

    localparam int unsigned DEF_NUM_BTNS        = 3;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int unsigned DEF_RST_STRETCH     = 255;
    localparam int unsigned DEF_LONG_CYCLES     = 100000000;

    // Counter width able to hold values up to n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchronizer, counter debouncer, level and edge pulses.
// Long-press detection is built only when BTN_COND_LONGPRESS_EN is defined.
module btn_debounce
    import btn_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic level_out,
    output logic rise_out,
    output logic fall_out,
    output logic long_out
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    // The STABLE-state sample counts as the first stable cycle, so CHECK finishes one early.
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_CYCLES - 2);

    logic          sync_q;
    logic          s_q;
    btn_state_t    state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          rise_q;
    logic          fall_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q  <= 1'b0;
            s_q     <= 1'b0;
            state   <= LO_STABLE;
            cnt     <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q <= btn_in;
            s_q    <= sync_q;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state)
                LO_STABLE: begin
                    if (s_q) begin
                        cnt   <= '0;
                        state <= LO_CHECK;
                    end
                end
                LO_CHECK: begin
                    if (!s_q) begin
                        state <= LO_STABLE;
                    end else if (cnt == CNT_DONE) begin
                        state   <= HI_STABLE;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI_STABLE: begin
                    if (!s_q) begin
                        cnt   <= '0;
                        state <= HI_CHECK;
                    end
                end
                HI_CHECK: begin
                    if (s_q) begin
                        state <= HI_STABLE;
                    end else if (cnt == CNT_DONE) begin
                        state   <= LO_STABLE;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= LO_STABLE;
            endcase
        end
    end

    assign level_out = level_q;
    assign rise_out  = rise_q;
    assign fall_out  = fall_q;

`ifdef BTN_COND_LONGPRESS_EN
    localparam int unsigned    LW        = cnt_width(LONG_CYCLES + 1);
    localparam logic [LW-1:0]  HOLD_FIRE = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0]  HOLD_SAT  = LW'(LONG_CYCLES);

    logic [LW-1:0] hold;
    logic          long_q;

    // Saturating one past the fire point is what blocks a repeat pulse until a fresh press.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hold   <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state == LO_CHECK && s_q && cnt == CNT_DONE) begin
                hold <= '0;
            end else if (state == HI_STABLE && s_q) begin
                if (hold == HOLD_FIRE) long_q <= 1'b1;
                if (hold != HOLD_SAT)  hold   <= hold + 1'b1;
            end
        end
    end

    assign long_out = long_q;
`else
    assign long_out = 1'b0;
`endif

endmodule

// File: rtl/btn_cond.sv
// Push-button front end: per-channel debouncers plus stretched system reset from channel 0.
// Optional long-press pulses are enabled by BTN_COND_LONGPRESS_EN.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = DEF_NUM_BTNS,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned RST_STRETCH     = DEF_RST_STRETCH,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic [NUM_BTNS-1:0] level_out,
    output logic [NUM_BTNS-1:0] rise_out,
    output logic [NUM_BTNS-1:0] fall_out,
    output logic                sys_rst_out,
    output logic [NUM_BTNS-1:0] long_out
);

    localparam int unsigned   SW       = cnt_width(RST_STRETCH + 1);
    localparam logic [SW-1:0] SW_RELOAD = SW'(RST_STRETCH);

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_debounce (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .btn_in    (btn_in[i]),
            .level_out (level_out[i]),
            .rise_out  (rise_out[i]),
            .fall_out  (fall_out[i]),
            .long_out  (long_out[i])
        );
    end

    logic [SW-1:0] stretch_cnt;
    logic          stretch_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            stretch_cnt <= SW_RELOAD;
            stretch_q   <= 1'b1;
        end else if (level_out[0]) begin
            stretch_cnt <= SW_RELOAD;
            stretch_q   <= 1'b1;
        end else if (stretch_cnt != '0) begin
            stretch_cnt <= stretch_cnt - 1'b1;
            stretch_q   <= (stretch_cnt != SW'(1));
        end else begin
            stretch_q   <= 1'b0;
        end
    end

    // The reload lands one cycle after level rises; OR-ing the level covers that first cycle.
    assign sys_rst_out = stretch_q | level_out[0];

endmodule
